// File: rtl/instr_fetch_seq_pkg.sv
// rtl/instr_fetch_seq_pkg.sv - shared types and helpers for the instruction fetch sequencer
package instr_fetch_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // Beat counter width; a single-beat instruction still needs one bit.
    function automatic int beat_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/instr_fetch_seq_lane_reg.sv
// rtl/instr_fetch_seq_lane_reg.sv - one instruction lane: load-enabled register with sync clear
module lane_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instr_fetch_seq.sv
// rtl/instr_fetch_seq.sv - multi-beat sequential instruction fetcher with redirect
module instr_fetch_seq
    import instr_fetch_seq_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                BUS_W    = 8,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                BIG_END  = 0
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               run,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [BUS_W-1:0]   mem_rdata,
    input  logic               mem_valid,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy
);

    localparam int BEATS = INSTR_W / BUS_W;
    localparam int CW    = beat_cnt_w(BEATS);

    fetch_state_t  state;
    logic [CW-1:0] beat;
    logic          last_beat;
    logic          accept_beat;

    assign last_beat   = (beat == CW'(BEATS - 1));
    assign accept_beat = (state == FETCH) && mem_valid && !redirect;
    // beat is held at zero outside FETCH, so this is simply pc there
    assign mem_addr    = pc + ADDR_W'(beat);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state       <= IDLE;
            beat        <= '0;
            pc          <= RESET_PC;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
        end else if (redirect) begin
            state       <= run ? FETCH : IDLE;
            beat        <= '0;
            pc          <= redirect_pc;
            mem_req     <= run;
            instr_valid <= 1'b0;
            busy        <= run;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state   <= FETCH;
                        beat    <= '0;
                        mem_req <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                FETCH: begin
                    if (mem_valid) begin
                        if (last_beat) begin
                            state       <= HOLD;
                            beat        <= '0;
                            mem_req     <= 1'b0;
                            instr_valid <= 1'b1;
                        end else begin
                            beat <= beat + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        pc          <= pc + ADDR_W'(BEATS);
                        state       <= run ? FETCH : IDLE;
                        mem_req     <= run;
                        instr_valid <= 1'b0;
                        busy        <= run;
                    end
                end
                default: begin
                    state       <= IDLE;
                    beat        <= '0;
                    mem_req     <= 1'b0;
                    instr_valid <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    // Each lane is claimed by exactly one beat; BIG_END mirrors the mapping.
    for (genvar i = 0; i < BEATS; i++) begin : g_lane
        localparam int BEAT_SEL = (BIG_END != 0) ? (BEATS - 1 - i) : i;

        lane_reg #(.W(BUS_W)) u_lane (
            .clk   (clk),
            .clr_n (rstb),
            .load  (accept_beat && (beat == CW'(BEAT_SEL))),
            .d     (mem_rdata),
            .q     (instr[i*BUS_W +: BUS_W])
        );
    end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb/tb_instr_fetch_seq.sv - directed and randomized checks of instr_fetch_seq against a reference model
module tb_instr_fetch_seq;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       run = 1'b0;
    logic       redirect = 1'b0;
    logic [7:0] redirect_pc = '0;
    logic       mem_valid = 1'b0;
    logic       instr_ready = 1'b0;

    logic [7:0]  mem [256];
    logic        req  [3];
    logic [7:0]  addr [3];
    logic [7:0]  rd   [3];
    logic [31:0] ins  [3];
    logic        iv   [3];
    logic [7:0]  pcs  [3];
    logic        bsy  [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_mem
        assign rd[k] = mem[addr[k]];
    end

    instr_fetch_seq dut_le (
        .clk(clk), .rstb(rstb), .run(run), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(req[0]), .mem_addr(addr[0]), .mem_rdata(rd[0]), .mem_valid(mem_valid),
        .instr(ins[0]), .instr_valid(iv[0]), .instr_ready(instr_ready), .pc(pcs[0]), .busy(bsy[0])
    );

    instr_fetch_seq #(.BIG_END(1)) dut_be (
        .clk(clk), .rstb(rstb), .run(run), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(req[1]), .mem_addr(addr[1]), .mem_rdata(rd[1]), .mem_valid(mem_valid),
        .instr(ins[1]), .instr_valid(iv[1]), .instr_ready(instr_ready), .pc(pcs[1]), .busy(bsy[1])
    );

    instr_fetch_seq #(.RESET_PC(8'hFE)) dut_wrap (
        .clk(clk), .rstb(rstb), .run(run), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(req[2]), .mem_addr(addr[2]), .mem_rdata(rd[2]), .mem_valid(mem_valid),
        .instr(ins[2]), .instr_valid(iv[2]), .instr_ready(instr_ready), .pc(pcs[2]), .busy(bsy[2])
    );

    // Reference model: 0 = idle, 1 = collecting bytes, 2 = holding a full word
    int         ms [3];
    int         mb [3];
    int         mp [3];
    logic [7:0] by [3][4];
    logic [31:0] mi [3];
    int         rp [3] = '{0, 0, 254};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            if (!rstb) begin
                ms[k] = 0; mb[k] = 0; mp[k] = rp[k]; mi[k] = 0;
            end else if (redirect) begin
                mp[k] = int'(redirect_pc); mb[k] = 0; ms[k] = run ? 1 : 0;
            end else if (ms[k] == 0) begin
                if (run) begin ms[k] = 1; mb[k] = 0; end
            end else if (ms[k] == 1) begin
                if (mem_valid) begin
                    by[k][mb[k]] = mem[(mp[k] + mb[k]) % 256];
                    if (mb[k] == 3) begin
                        ms[k] = 2; mb[k] = 0;
                        if (k == 1) mi[k] = {by[k][0], by[k][1], by[k][2], by[k][3]};
                        else        mi[k] = {by[k][3], by[k][2], by[k][1], by[k][0]};
                    end else begin
                        mb[k] = mb[k] + 1;
                    end
                end
            end else begin
                if (instr_ready) begin
                    mp[k] = (mp[k] + 4) % 256; ms[k] = run ? 1 : 0;
                end
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("req%0d", k),   32'(req[k]),  32'(ms[k] == 1));
            chk($sformatf("valid%0d", k), 32'(iv[k]),   32'(ms[k] == 2));
            chk($sformatf("busy%0d", k),  32'(bsy[k]),  32'(ms[k] != 0));
            chk($sformatf("pc%0d", k),    32'(pcs[k]),  32'(mp[k]));
            chk($sformatf("addr%0d", k),  32'(addr[k]), 32'((mp[k] + mb[k]) % 256));
            if (ms[k] == 2) chk($sformatf("instr%0d", k), ins[k], mi[k]);
        end
    endtask

    initial begin
        logic [31:0] exp_f0;
        int          mv [6] = '{1, 1, 0, 0, 1, 1};
        int          ea [5] = '{5, 6, 6, 6, 7};

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        exp_f0 = {mem[8'hF3], mem[8'hF2], mem[8'hF1], mem[8'hF0]};

        // reset state
        step();
        step();
        chk("rst_instr", ins[0], 32'h0);
        chk("rst_wrap_addr", 32'(addr[2]), 32'hFE);

        // zero-wait sequential fetch from 0 and from FE
        rstb = 1'b1; run = 1'b1; mem_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("addr_seq", 32'(addr[0]), 32'(c));
            chk("addr_wrap_seq", 32'(addr[2]), 32'((254 + c) % 256));
            chk("valid_early", 32'(iv[0]), 32'h0);
        end
        step();
        chk("valid_at_4", 32'(iv[0]), 32'h1);
        chk("instr_le", ins[0], 32'h44332211);
        chk("instr_be", ins[1], 32'h11223344);
        step();
        chk("hold_stable", ins[0], 32'h44332211);

        // accept: pc advances and fetch restarts with no idle cycle
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("pc_adv", 32'(pcs[0]), 32'h4);
        chk("pc_wrap_adv", 32'(pcs[2]), 32'h2);
        chk("b2b_req", 32'(req[0]), 32'h1);

        // two wait states on beat 2
        for (int c = 0; c < 5; c++) begin
            mem_valid = mv[c][0];
            step();
            chk("wait_addr", 32'(addr[0]), 32'(ea[c]));
            chk("wait_valid_low", 32'(iv[0]), 32'h0);
        end
        mem_valid = mv[5][0];
        step();
        chk("wait_valid_6", 32'(iv[0]), 32'h1);

        // redirect during beat 1
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        step();
        chk("pre_redir_addr", 32'(addr[0]), 32'h9);
        redirect = 1'b1; redirect_pc = 8'hF0;
        step();
        redirect = 1'b0;
        chk("redir_addr", 32'(addr[0]), 32'hF0);
        chk("redir_valid", 32'(iv[0]), 32'h0);
        for (int c = 0; c < 4; c++) step();
        chk("redir_instr", ins[0], exp_f0);

        // reset while holding
        rstb = 1'b0;
        step();
        chk("hold_rst_valid", 32'(iv[0]), 32'h0);
        chk("hold_rst_pc", 32'(pcs[0]), 32'h0);
        chk("hold_rst_busy", 32'(bsy[0]), 32'h0);
        rstb = 1'b1;

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            rstb        = ($urandom_range(99) != 0);
            run         = ($urandom_range(7) != 0);
            mem_valid   = ($urandom_range(3) != 0);
            instr_ready = ($urandom_range(2) == 0);
            redirect    = ($urandom_range(19) == 0);
            redirect_pc = 8'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
